// File: rtl/dino_pkg.sv
// dino_pkg: state encoding, sprite-select codes and pose decode for the T-Rex controller.
package dino_pkg;
  typedef enum logic [1:0] {RUN, DUCK, JUMP, DEAD} state_e;
  localparam logic [3:0] SEL_JUMP  = 4'd0;
  localparam logic [3:0] SEL_RUN0  = 4'd1;
  localparam logic [3:0] SEL_RUN1  = 4'd2;
  localparam logic [3:0] SEL_DUCK0 = 4'd3;
  localparam logic [3:0] SEL_DUCK1 = 4'd4;
  localparam logic [3:0] SEL_DEAD  = 4'd5;
  function automatic logic [3:0] sel_of(state_e s, logic leg);
    return s == JUMP ? SEL_JUMP :
           s == DEAD ? SEL_DEAD :
           s == DUCK ? (leg ? SEL_DUCK1 : SEL_DUCK0) :
                       (leg ? SEL_RUN1 : SEL_RUN0);
  endfunction
endpackage

// File: rtl/leg_anim_counter.sv
// leg_anim_counter: divides enabled ticks by TICKS and toggles the leg frame on each wrap.
module leg_anim_counter #(
  parameter int TICKS = 6
) (
  input  logic clk,
  input  logic rst,
  input  logic en_i,
  input  logic clr_i,
  output logic leg_o
);
  localparam int CW = TICKS > 1 ? $clog2(TICKS) : 1;
  logic [CW-1:0] cnt_q;
  logic          leg_q;
  logic          wrap;
  assign wrap  = cnt_q == CW'(TICKS - 1);
  assign leg_o = leg_q;
  always_ff @(posedge clk) begin
    if (rst || clr_i) begin
      cnt_q <= '0;
      leg_q <= 1'b0;
    end else if (en_i) begin
      cnt_q <= wrap ? '0 : cnt_q + 1'b1;
      leg_q <= leg_q ^ wrap;
    end
  end
endmodule

// File: rtl/dino_motion_ctrl.sv
// dino_motion_ctrl: T-Rex height/velocity and RUN/DUCK/JUMP/DEAD pose control; define VARIABLE_JUMP_EN for short hops on early release.
module dino_motion_ctrl
  import dino_pkg::*;
#(
  parameter int Y_W        = 10,
  parameter int GROUND_Y   = 360,
  parameter int DINO_H     = 47,
  parameter int DUCK_H     = 30,
  parameter int JUMP_V0    = 20,
  parameter int GRAVITY    = 1,
  parameter int MAX_FALL_V = 20,
  parameter int ANIM_TICKS = 6,
  parameter int JUMP_CUT   = 6
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           tick,
  input  logic           jump,
  input  logic           duck,
  input  logic           hit,
  output logic [Y_W-1:0] dino_y,
  output logic [3:0]     dino_sel,
  output logic           airborne,
  output logic           on_ground,
  output logic           is_dead
);
`ifdef VARIABLE_JUMP_EN
  localparam bit CUT_EN = 1'b1;
`else
  localparam bit CUT_EN = 1'b0;
`endif
  localparam logic signed [Y_W:0] V0   = (Y_W+1)'(JUMP_V0);
  localparam logic signed [Y_W:0] G    = (Y_W+1)'(GRAVITY);
  localparam logic signed [Y_W:0] VMIN = (Y_W+1)'(-MAX_FALL_V);
  localparam logic signed [Y_W:0] CUT  = (Y_W+1)'(JUMP_CUT);
  state_e                  state_q;
  logic [Y_W-1:0]          h_q;
  logic signed [Y_W:0]     v_q;
  logic                    armed_q;
  logic signed [Y_W:0]     v_eff, v_dec, v_nx;
  logic signed [Y_W+1:0]   hv;
  logic                    land, leg, anim_en, anim_clr;
  logic [Y_W-1:0]          cur_h;
  // The release cut is applied to the velocity before it moves the dino this tick.
  assign v_eff = (CUT_EN && !jump && v_q > CUT) ? CUT : v_q;
  assign hv    = $signed({2'b00, h_q}) + $signed({v_eff[Y_W], v_eff});
  assign land  = hv[Y_W+1] || hv == '0;
  assign v_dec = v_eff - G;
  assign v_nx  = v_dec < VMIN ? VMIN : v_dec;
  assign anim_en  = tick && !hit && (state_q == RUN || state_q == DUCK);
  assign anim_clr = tick && state_q == DEAD && jump && armed_q;
  leg_anim_counter #(.TICKS(ANIM_TICKS)) u_anim (
    .clk   (clk),
    .rst   (rst),
    .en_i  (anim_en),
    .clr_i (anim_clr),
    .leg_o (leg)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
      h_q     <= '0;
      v_q     <= '0;
      armed_q <= 1'b0;
    end else if (hit && state_q != DEAD) begin
      state_q <= DEAD;
    end else if (tick) begin
      case (state_q)
        RUN, DUCK: begin
          if (jump) begin
            state_q <= JUMP;
            v_q     <= V0;
          end else begin
            state_q <= duck ? DUCK : RUN;
          end
        end
        JUMP: begin
          if (land) begin
            h_q     <= '0;
            v_q     <= '0;
            state_q <= duck ? DUCK : RUN;
          end else begin
            h_q <= hv[Y_W-1:0];
            v_q <= v_nx;
          end
        end
        default: begin
          // Restart needs a fresh press: the jump that killed the dino must be released first.
          if (jump && armed_q) begin
            state_q <= RUN;
            h_q     <= '0;
            v_q     <= '0;
            armed_q <= 1'b0;
          end else if (!jump) begin
            armed_q <= 1'b1;
          end
        end
      endcase
    end
  end
  assign cur_h     = state_q == DUCK ? Y_W'(DUCK_H) : Y_W'(DINO_H);
  assign dino_y    = Y_W'(GROUND_Y) - cur_h - h_q;
  assign dino_sel  = sel_of(state_q, leg);
  assign airborne  = |h_q;
  assign on_ground = h_q == '0 && state_q != DEAD;
  assign is_dead   = state_q == DEAD;
endmodule

// File: tb/tb_dino_motion_ctrl.sv
// tb_dino_motion_ctrl: directed stimulus with a queued scoreboard drained by a negedge monitor.
module tb_dino_motion_ctrl;
`ifdef VARIABLE_JUMP_EN
  localparam int PEAK_T = 8;
  localparam int PEAK_H = 60;
  localparam int LAND_T = 20;
`else
  localparam int PEAK_T = 20;
  localparam int PEAK_H = 210;
  localparam int LAND_T = 41;
`endif
  localparam logic [16:0] M_ALL = '1;
  localparam logic [16:0] M_AIR = 17'b100;
  typedef struct {
    string       name;
    logic [16:0] exp;
    logic [16:0] mask;
  } exp_t;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tick = 1'b0, jump = 1'b0, duck = 1'b0, hit = 1'b0;
  logic [9:0] dino_y;
  logic [3:0] dino_sel;
  logic       airborne, on_ground, is_dead;
  exp_t       sb[$];
  exp_t       e;
  logic [16:0] act;
  int         checks = 0;
  int         passed = 0;
  dino_motion_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .tick      (tick),
    .jump      (jump),
    .duck      (duck),
    .hit       (hit),
    .dino_y    (dino_y),
    .dino_sel  (dino_sel),
    .airborne  (airborne),
    .on_ground (on_ground),
    .is_dead   (is_dead)
  );
  always #5 clk = ~clk;
  function automatic logic [16:0] vec(int y, int s, bit a, bit g, bit d);
    return {10'(y), 4'(s), a, g, d};
  endfunction
  task automatic push_exp(input string n, input logic [16:0] x, input logic [16:0] m);
    sb.push_back('{n, x, m});
  endtask
  task automatic step(input logic t, input logic j, input logic d, input logic h);
    @(posedge clk); #1;
    tick = t; jump = j; duck = d; hit = h;
    @(posedge clk); #1;
    tick = 1'b0; hit = 1'b0;
  endtask
  always @(negedge clk) begin
    while (sb.size() > 0) begin
      e   = sb.pop_front();
      act = {dino_y, dino_sel, airborne, on_ground, is_dead};
      checks++;
      if ((act & e.mask) === (e.exp & e.mask)) passed++;
      else $display("FAIL %s: got y=%0d sel=%0d air=%b gnd=%b dead=%b, want y=%0d sel=%0d air=%b gnd=%b dead=%b (mask %h)",
                    e.name, act[16:7], act[6:3], act[2], act[1], act[0],
                    e.exp[16:7], e.exp[6:3], e.exp[2], e.exp[1], e.exp[0], e.mask);
    end
  end
  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, want finished", $time);
    $fatal(1);
  end
  initial begin
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    push_exp("reset", vec(313, 1, 0, 1, 0), M_ALL);
    repeat (5) step(1, 0, 0, 0);
    push_exp("anim_5", vec(313, 1, 0, 1, 0), M_ALL);
    step(1, 0, 0, 0);
    push_exp("anim_6", vec(313, 2, 0, 1, 0), M_ALL);
    // Jump held for three ticks then released: fixed arc by default, short hop with the cut.
    step(1, 1, 0, 0);
    push_exp("jump_t0", vec(313, 0, 0, 1, 0), M_ALL);
    for (int k = 1; k <= LAND_T; k++) begin
      step(1, k <= 2, 0, 0);
      if (k < LAND_T) push_exp($sformatf("air_t%0d", k), vec(0, 0, 1, 0, 0), M_AIR);
      if (k == PEAK_T || k == PEAK_T + 1)
        push_exp($sformatf("peak_t%0d", k), vec(313 - PEAK_H, 0, 1, 0, 0), M_ALL);
      if (k == LAND_T) push_exp("land", vec(313, 2, 0, 1, 0), M_ALL);
    end
    step(1, 0, 1, 0);
    push_exp("duck_1", vec(330, 4, 0, 1, 0), M_ALL);
    repeat (4) step(1, 0, 1, 0);
    push_exp("duck_5", vec(330, 3, 0, 1, 0), M_ALL);
    repeat (6) step(1, 0, 1, 0);
    push_exp("duck_11", vec(330, 4, 0, 1, 0), M_ALL);
    step(1, 1, 1, 0);
    push_exp("jump_beats_duck", vec(313, 0, 0, 1, 0), M_ALL);
    step(1, 1, 1, 0);
    push_exp("duck_ignored_air", vec(293, 0, 1, 0, 0), M_ALL);
    repeat (39) step(1, 1, 1, 0);
    step(1, 0, 1, 0);
    push_exp("land_into_duck", vec(330, 4, 0, 1, 0), M_ALL);
    step(1, 0, 0, 0);
    push_exp("duck_release", vec(313, 2, 0, 1, 0), M_ALL);
    repeat (4) step(1, 1, 0, 0);
    push_exp("h57", vec(256, 0, 1, 0, 0), M_ALL);
    step(0, 1, 0, 1);
    push_exp("hit_dead", vec(256, 5, 1, 0, 1), M_ALL);
    repeat (2) step(1, 1, 0, 0);
    step(1, 1, 0, 1);
    push_exp("held_no_restart", vec(256, 5, 1, 0, 1), M_ALL);
    step(1, 0, 0, 0);
    push_exp("armed_still_dead", vec(256, 5, 1, 0, 1), M_ALL);
    step(1, 1, 0, 0);
    push_exp("restart", vec(313, 1, 0, 1, 0), M_ALL);
    step(1, 0, 0, 0);
    repeat (11) step(1, 1, 0, 0);
    push_exp("h155", vec(158, 0, 1, 0, 0), M_ALL);
    @(posedge clk); #1;
    rst = 1'b1; hit = 1'b1; jump = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0; hit = 1'b0;
    push_exp("rst_mid_jump", vec(313, 1, 0, 1, 0), M_ALL);
    @(posedge clk); #1;
    push_exp("rst_beats_hit", vec(313, 1, 0, 1, 0), M_ALL);
    repeat (3) @(posedge clk);
    checks++;
    if (sb.size() == 0) passed++;
    else $display("FAIL drain: got %0d pending, want 0", sb.size());
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
